// File: rtl/mod_updown_counter.sv
// Parametrised modulo-MOD up/down counter with load, wrap/saturate mode, tc and wrap pulse.
// Optional sticky boundary flag (ovf, cleared by ovf_clr) when CNT_OVF_STICKY_EN is defined.
module mod_updown_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MOD      = 10,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef CNT_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MOD - 1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign at_max  = (q == Q_MAX);
  assign at_zero = (q == '0);
  assign tc      = en & ((up & at_max) | (~up & at_zero));

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = (load_val > Q_MAX) ? Q_MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          q_nxt = q + WIDTH'(1);
        end else if (SATURATE == 0) begin
          // Explicit zero rather than relying on overflow, so MOD < 2**WIDTH also works.
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_nxt = q - WIDTH'(1);
        end else if (SATURATE == 0) begin
          q_nxt    = Q_MAX;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

`ifdef CNT_OVF_STICKY_EN
  // Set beats clear: a boundary hit coincident with ovf_clr must not be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (tc && !load) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter across wrap, saturate, full-range and MOD=2 builds.
// Exercises the sticky ovf flag when CNT_OVF_STICKY_EN is defined.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q_a, q_s;
  logic [2:0] q_f;
  logic [0:0] q_2;
  logic       tc_a, tc_s, tc_f, tc_2;
  logic       wrap_a, wrap_s, wrap_f, wrap_2;
`ifdef CNT_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf_a, ovf_s, ovf_f, ovf_2;
`endif

  int pass_cnt = 0;
  int total    = 0;

  mod_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf_a),
`endif
    .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  mod_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf_s),
`endif
    .q(q_s), .tc(tc_s), .wrap(wrap_s)
  );

  mod_updown_counter #(.WIDTH(3), .MOD(8), .SATURATE(0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
`ifdef CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf_f),
`endif
    .q(q_f), .tc(tc_f), .wrap(wrap_f)
  );

  mod_updown_counter #(.WIDTH(1), .MOD(2), .SATURATE(0)) dut_2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[0:0]),
`ifdef CNT_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(ovf_2),
`endif
    .q(q_2), .tc(tc_2), .wrap(wrap_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
`ifdef CNT_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    step();
    step();
    total++; if (q_a !== 4'd0) $display("FAIL reset_q_a: got %0d expected 0", q_a); else pass_cnt++;
    total++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap_a: got %0b expected 0", wrap_a); else pass_cnt++;
    total++; if (tc_a !== 1'b0) $display("FAIL reset_tc_a: got %0b expected 0", tc_a); else pass_cnt++;
    total++; if (q_s !== 4'd0) $display("FAIL reset_q_s: got %0d expected 0", q_s); else pass_cnt++;
    total++; if (q_f !== 3'd0) $display("FAIL reset_q_f: got %0d expected 0", q_f); else pass_cnt++;
    total++; if (q_2 !== 1'd0) $display("FAIL reset_q_2: got %0d expected 0", q_2); else pass_cnt++;
    // tc depends only on en/up/q, so it is visible even during reset
    en = 1'b1; up = 1'b0; #1;
    total++; if (tc_a !== 1'b1) $display("FAIL reset_tc_down: got %0b expected 1", tc_a); else pass_cnt++;
    en = 1'b0;
    step();
    total++; if (q_a !== 4'd0) $display("FAIL reset_hold_q: got %0d expected 0", q_a); else pass_cnt++;
  endtask

  task automatic test_count_up();
    int exp_q;
    rst = 1'b0; en = 1'b1; up = 1'b1; #1;
    total++; if (tc_a !== 1'b0) $display("FAIL up_tc_start: got %0b expected 0", tc_a); else pass_cnt++;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_q = i % 10;
      total++; if (q_a !== 4'(exp_q)) $display("FAIL up_q step %0d: got %0d expected %0d", i, q_a, exp_q); else pass_cnt++;
      total++; if (wrap_a !== (i == 10)) $display("FAIL up_wrap step %0d: got %0b expected %0b", i, wrap_a, (i == 10)); else pass_cnt++;
      total++; if (tc_a !== (exp_q == 9)) $display("FAIL up_tc step %0d: got %0b expected %0b", i, tc_a, (exp_q == 9)); else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_load_down();
    int seq [5] = '{2, 1, 0, 9, 8};
    int prev;
    load = 1'b1; load_val = 4'd3;
    step();
    total++; if (q_a !== 4'd3) $display("FAIL load3_q: got %0d expected 3", q_a); else pass_cnt++;
    total++; if (wrap_a !== 1'b0) $display("FAIL load3_wrap: got %0b expected 0", wrap_a); else pass_cnt++;
    load = 1'b0; en = 1'b1; up = 1'b0;
    prev = 3;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (tc_a !== (prev == 0)) $display("FAIL down_tc at q=%0d: got %0b expected %0b", prev, tc_a, (prev == 0)); else pass_cnt++;
      step();
      total++; if (q_a !== 4'(seq[i])) $display("FAIL down_q step %0d: got %0d expected %0d", i, q_a, seq[i]); else pass_cnt++;
      total++; if (wrap_a !== (prev == 0)) $display("FAIL down_wrap step %0d: got %0b expected %0b", i, wrap_a, (prev == 0)); else pass_cnt++;
      prev = seq[i];
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    rst = 1'b1; step(); rst = 1'b0;
    load = 1'b1; load_val = 4'd8;
    step();
    total++; if (q_s !== 4'd8) $display("FAIL sat_load_q: got %0d expected 8", q_s); else pass_cnt++;
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (q_s !== 4'd9) $display("FAIL sat_up_q step %0d: got %0d expected 9", i, q_s); else pass_cnt++;
      total++; if (wrap_s !== 1'b0) $display("FAIL sat_up_wrap step %0d: got %0b expected 0", i, wrap_s); else pass_cnt++;
    end
    total++; if (tc_s !== 1'b1) $display("FAIL sat_tc_hold: got %0b expected 1", tc_s); else pass_cnt++;
    up = 1'b0;
    step();
    total++; if (q_s !== 4'd8) $display("FAIL sat_down_q1: got %0d expected 8", q_s); else pass_cnt++;
    step();
    total++; if (q_s !== 4'd7) $display("FAIL sat_down_q2: got %0d expected 7", q_s); else pass_cnt++;
    // down-saturate at zero
    load = 1'b1; load_val = 4'd0; step(); load = 1'b0;
    step();
    total++; if (q_s !== 4'd0) $display("FAIL sat_zero_q: got %0d expected 0", q_s); else pass_cnt++;
    total++; if (wrap_s !== 1'b0) $display("FAIL sat_zero_wrap: got %0b expected 0", wrap_s); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_clamp_priority();
    load = 1'b1; load_val = 4'd15; en = 1'b1; up = 1'b1;
    step();
    total++; if (q_a !== 4'd9) $display("FAIL clamp_q_a: got %0d expected 9", q_a); else pass_cnt++;
    total++; if (q_s !== 4'd9) $display("FAIL clamp_q_s: got %0d expected 9", q_s); else pass_cnt++;
    total++; if (tc_a !== 1'b1) $display("FAIL tc_ignores_load: got %0b expected 1", tc_a); else pass_cnt++;
    step();
    total++; if (q_a !== 4'd9) $display("FAIL load_over_en_q: got %0d expected 9", q_a); else pass_cnt++;
    total++; if (wrap_a !== 1'b0) $display("FAIL load_no_wrap: got %0b expected 0", wrap_a); else pass_cnt++;
    rst = 1'b1;
    step();
    total++; if (q_a !== 4'd0) $display("FAIL rst_over_load_q: got %0d expected 0", q_a); else pass_cnt++;
    total++; if (wrap_a !== 1'b0) $display("FAIL rst_over_load_wrap: got %0b expected 0", wrap_a); else pass_cnt++;
    rst = 1'b0; load_val = 4'd9;
    step();
    load = 1'b0; rst = 1'b1;
    step();
    total++; if (q_a !== 4'd0) $display("FAIL rst_at_wrap_q: got %0d expected 0", q_a); else pass_cnt++;
    total++; if (wrap_a !== 1'b0) $display("FAIL rst_at_wrap_wrap: got %0b expected 0", wrap_a); else pass_cnt++;
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_full_range();
    rst = 1'b1; step(); rst = 1'b0;
    load = 1'b1; load_val = 4'd7;
    step();
    total++; if (q_f !== 3'd7) $display("FAIL full_load_q: got %0d expected 7", q_f); else pass_cnt++;
    load = 1'b0; en = 1'b1; up = 1'b1; #1;
    total++; if (tc_f !== 1'b1) $display("FAIL full_tc_up: got %0b expected 1", tc_f); else pass_cnt++;
    step();
    total++; if (q_f !== 3'd0) $display("FAIL full_up_wrap_q: got %0d expected 0", q_f); else pass_cnt++;
    total++; if (wrap_f !== 1'b1) $display("FAIL full_up_wrap: got %0b expected 1", wrap_f); else pass_cnt++;
    up = 1'b0; #1;
    total++; if (tc_f !== 1'b1) $display("FAIL full_tc_down: got %0b expected 1", tc_f); else pass_cnt++;
    step();
    total++; if (q_f !== 3'd7) $display("FAIL full_down_wrap_q: got %0d expected 7", q_f); else pass_cnt++;
    total++; if (wrap_f !== 1'b1) $display("FAIL full_down_wrap: got %0b expected 1", wrap_f); else pass_cnt++;
    en = 1'b0;
    step();
    total++; if (q_f !== 3'd7) $display("FAIL full_hold_q: got %0d expected 7", q_f); else pass_cnt++;
    total++; if (wrap_f !== 1'b0) $display("FAIL full_wrap_drop: got %0b expected 0", wrap_f); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1; up = 1'b1;
    step();
    total++; if (q_2 !== 1'd1 || wrap_2 !== 1'b0) $display("FAIL m2_s1: got q=%0d wrap=%0b expected q=1 wrap=0", q_2, wrap_2); else pass_cnt++;
    step();
    total++; if (q_2 !== 1'd0 || wrap_2 !== 1'b1) $display("FAIL m2_s2: got q=%0d wrap=%0b expected q=0 wrap=1", q_2, wrap_2); else pass_cnt++;
    up = 1'b0;
    step();
    total++; if (q_2 !== 1'd1 || wrap_2 !== 1'b1) $display("FAIL m2_s3: got q=%0d wrap=%0b expected q=1 wrap=1", q_2, wrap_2); else pass_cnt++;
    step();
    total++; if (q_2 !== 1'd0 || wrap_2 !== 1'b0) $display("FAIL m2_s4: got q=%0d wrap=%0b expected q=0 wrap=0", q_2, wrap_2); else pass_cnt++;
    en = 1'b0;
  endtask

`ifdef CNT_OVF_STICKY_EN
  task automatic test_ovf();
    rst = 1'b1; ovf_clr = 1'b0; step(); rst = 1'b0;
    total++; if (ovf_a !== 1'b0) $display("FAIL ovf_reset: got %0b expected 0", ovf_a); else pass_cnt++;
    load = 1'b1; load_val = 4'd9;
    step();
    total++; if (ovf_a !== 1'b0) $display("FAIL ovf_after_load: got %0b expected 0", ovf_a); else pass_cnt++;
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    total++; if (ovf_a !== 1'b1 || q_a !== 4'd0) $display("FAIL ovf_set: got ovf=%0b q=%0d expected ovf=1 q=0", ovf_a, q_a); else pass_cnt++;
    en = 1'b0;
    step();
    total++; if (ovf_a !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", ovf_a); else pass_cnt++;
    load = 1'b1; load_val = 4'd5; step(); load = 1'b0;
    ovf_clr = 1'b1;
    step();
    total++; if (ovf_a !== 1'b0 || q_a !== 4'd5) $display("FAIL ovf_clr: got ovf=%0b q=%0d expected ovf=0 q=5", ovf_a, q_a); else pass_cnt++;
    ovf_clr = 1'b0; load = 1'b1; load_val = 4'd9; en = 1'b1; up = 1'b1;
    step();
    step();
    total++; if (ovf_a !== 1'b0 || q_a !== 4'd9) $display("FAIL ovf_load_blocks: got ovf=%0b q=%0d expected ovf=0 q=9", ovf_a, q_a); else pass_cnt++;
    load = 1'b0; ovf_clr = 1'b1;
    step();
    total++; if (ovf_a !== 1'b1 || q_a !== 4'd0) $display("FAIL ovf_set_beats_clr: got ovf=%0b q=%0d expected ovf=1 q=0", ovf_a, q_a); else pass_cnt++;
    ovf_clr = 1'b0; en = 1'b0;
    // saturate-hold also counts as a boundary hit
    total++; if (ovf_s !== 1'b1) $display("FAIL ovf_sat: got %0b expected 1", ovf_s); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_saturate();
    test_clamp_priority();
    test_full_range();
    test_back_to_back();
`ifdef CNT_OVF_STICKY_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
